// File: rtl/pht_update_ctrl_pkg.sv
// Shared encodings and types for the PHT write sequencer.
package pht_update_ctrl_pkg;

   localparam int PHT_SIZE = 256;
   localparam int IDX_W    = 8;

   // 2-bit saturating counter states
   localparam logic [1:0] PHT_SNT = 2'b00;
   localparam logic [1:0] PHT_WNT = 2'b01;
   localparam logic [1:0] PHT_WT  = 2'b10;
   localparam logic [1:0] PHT_ST  = 2'b11;

   // Value the table applies when pht_wmode selects an init write
   localparam logic [1:0] INIT_STATE = PHT_WNT;

   localparam logic PHT_WMODE_UPDATE = 1'b0;
   localparam logic PHT_WMODE_INIT   = 1'b1;

   typedef enum logic {
      CTRL_INIT = 1'b0,
      CTRL_RUN  = 1'b1
   } ctrl_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
   } upd_entry_t;

endpackage

// File: rtl/pht_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates until RUN drains them.
module pht_upd_fifo
   import pht_update_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic       pop,
   input  upd_entry_t din,
   output logic       full,
   output logic       empty,
   output upd_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   upd_entry_t       mem_q [DEPTH];
   upd_entry_t       mem_d [DEPTH];
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_FULL);
   assign empty   = (cnt_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointers/count; power-of-two depth lets pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; entries are only read once counted valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pht_update_ctrl.sv
// Sequences PHT writes: full-table init sweep after reset/flush, then one
// queued branch update per cycle. All command outputs are registered.
module pht_update_ctrl
   import pht_update_ctrl_pkg::*;
#(
   parameter int Q_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_valid,
   input  logic [15:0]      upd_pc,
   input  logic             upd_taken,
   output logic             upd_ready,
   input  logic             flush_req,
   output logic             pred_valid,
   output logic             pht_we,
   output logic [IDX_W-1:0] pht_waddr,
   output logic             pht_wmode,
   output logic             pht_taken,
   output logic [15:0]      drop_cnt
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PHT_SIZE - 1);

   ctrl_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             we_q, we_d;
   logic [IDX_W-1:0] waddr_q, waddr_d;
   logic             wmode_q, wmode_d;
   logic             taken_q, taken_d;
   logic             pvld_q, pvld_d;
   logic [15:0]      drop_q, drop_d;

   logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
   upd_entry_t       fifo_din, fifo_head;
   logic             unused_pc;

   // Only pc[9:2] selects an entry; remaining PC bits are deliberately ignored
   assign unused_pc = ^upd_pc;

   // Ready reflects the current occupancy only; a same-cycle pop gives no credit
   assign upd_ready = !rst && !fifo_full;
   assign fifo_push = upd_valid && upd_ready && !flush_req;
   assign fifo_din  = '{idx: upd_pc[IDX_W+1:2], taken: upd_taken};

   pht_upd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_req),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Next-state and next-command selection; flush overrides both phases
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      we_d     = 1'b0;
      waddr_d  = '0;
      wmode_d  = PHT_WMODE_UPDATE;
      taken_d  = 1'b0;
      pvld_d   = 1'b0;
      fifo_pop = 1'b0;
      drop_d   = drop_q;

      if (upd_valid && !upd_ready && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end

      if (flush_req) begin
         state_d = CTRL_INIT;
         idx_d   = '0;
      end else begin
         case (state_q)
            CTRL_INIT: begin
               we_d    = 1'b1;
               wmode_d = PHT_WMODE_INIT;
               waddr_d = idx_q;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = CTRL_RUN;
               end
            end
            default: begin
               // Sweep's last write has already been visible for a cycle
               pvld_d = 1'b1;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  we_d     = 1'b1;
                  waddr_d  = fifo_head.idx;
                  taken_d  = fifo_head.taken;
               end
            end
         endcase
      end
   end

   // Controller FSM with registered command outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CTRL_INIT;
         idx_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wmode_q <= PHT_WMODE_UPDATE;
         taken_q <= 1'b0;
         pvld_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wmode_q <= wmode_d;
         taken_q <= taken_d;
         pvld_q  <= pvld_d;
         drop_q  <= drop_d;
      end
   end

   assign pht_we     = we_q;
   assign pht_waddr  = waddr_q;
   assign pht_wmode  = wmode_q;
   assign pht_taken  = taken_q;
   assign pred_valid = pvld_q;
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Directed bench for pht_update_ctrl: vector table for RUN traffic plus
// hand-written sweep/flush/reset sequences, with a small PHT model.
module tb_pht_update_ctrl;

   logic        clk;
   logic        rst;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic        upd_taken;
   logic        upd_ready;
   logic        flush_req;
   logic        pred_valid;
   logic        pht_we;
   logic [7:0]  pht_waddr;
   logic        pht_wmode;
   logic        pht_taken;
   logic [15:0] drop_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [1:0] pht_m [256];

   typedef struct {
      logic        v;
      logic [15:0] pc;
      logic        tk;
      logic        e_we;
      logic [7:0]  e_addr;
      logic        e_tk;
   } vec_t;

   vec_t tbl [15];

   // Updates offered while the table is sweeping
   logic [15:0] ip_pc [6];
   logic        ip_tk [6];

   pht_update_ctrl #(.Q_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_ready  (upd_ready),
      .flush_req  (flush_req),
      .pred_valid (pred_valid),
      .pht_we     (pht_we),
      .pht_waddr  (pht_waddr),
      .pht_wmode  (pht_wmode),
      .pht_taken  (pht_taken),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PHT model: applies each write command at the negedge like the real table
   always @(negedge clk) begin
      if (pht_we === 1'b1) begin
         if (pht_wmode) pht_m[pht_waddr] <= 2'b01;
         else if (pht_taken && pht_m[pht_waddr] != 2'b11) pht_m[pht_waddr] <= pht_m[pht_waddr] + 2'b01;
         else if (!pht_taken && pht_m[pht_waddr] != 2'b00) pht_m[pht_waddr] <= pht_m[pht_waddr] - 2'b01;
      end
   end

   function automatic vec_t mk(input logic v, input logic [15:0] pc, input logic tk,
                               input logic e_we, input logic [7:0] e_addr, input logic e_tk);
      vec_t r;
      r.v = v; r.pc = pc; r.tk = tk; r.e_we = e_we; r.e_addr = e_addr; r.e_tk = e_tk;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // nlen init-write cycles; the first npush cycles also offer ip_pc/ip_tk
   task automatic sweep(input string nm, input int npush, input int nlen);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < nlen; i++) begin
         if (i < npush) begin
            upd_valid = 1'b1;
            upd_pc    = ip_pc[i];
            upd_taken = ip_tk[i];
            chk($sformatf("%s_ready%0d", nm, i), {31'd0, upd_ready}, {31'd0, (i < 4)});
         end else begin
            upd_valid = 1'b0;
         end
         step();
         if (pht_we !== 1'b1 || pht_wmode !== 1'b1 || pht_waddr !== 8'(i) ||
             pht_taken !== 1'b0 || pred_valid !== 1'b0) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      upd_valid = 1'b0;
      vec_cnt++;
      if (bad != 0) begin
         err_cnt++;
         $display("FAIL %s: %0d bad init cycles, first at idx %0d (we=%0b mode=%0b addr=%0h pv=%0b)",
                  nm, bad, first, pht_we, pht_wmode, pht_waddr, pred_valid);
      end
   endtask

   task automatic chk_model_init(input string nm);
      int bad = 0;
      for (int i = 0; i < 256; i++) if (pht_m[i] !== 2'b01) bad++;
      chk(nm, bad, 0);
   endtask

   // {we, wmode, taken, waddr, pred_valid}
   function automatic logic [31:0] cmd();
      return {20'd0, pht_we, pht_wmode, pht_taken, pht_waddr, pred_valid};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) pht_m[i] = 2'b10;

      tbl[0]  = mk(1, 16'h0124, 1, 0, 8'h00, 0);
      tbl[1]  = mk(0, 16'h0000, 0, 1, 8'h49, 1);
      tbl[2]  = mk(0, 16'h0000, 0, 0, 8'h00, 0);
      tbl[3]  = mk(1, 16'h0000, 1, 0, 8'h00, 0);
      tbl[4]  = mk(1, 16'h0004, 0, 1, 8'h00, 1);
      tbl[5]  = mk(1, 16'h03FC, 1, 1, 8'h01, 0);
      tbl[6]  = mk(1, 16'hFC00, 1, 1, 8'hFF, 1);
      tbl[7]  = mk(1, 16'h1238, 0, 1, 8'h00, 1);
      tbl[8]  = mk(1, 16'hABCD, 0, 1, 8'h8E, 0);
      tbl[9]  = mk(1, 16'h0200, 1, 1, 8'hF3, 0);
      tbl[10] = mk(1, 16'h0101, 0, 1, 8'h80, 1);
      tbl[11] = mk(1, 16'h7FFF, 1, 1, 8'h40, 0);
      tbl[12] = mk(1, 16'h0010, 0, 1, 8'hFF, 1);
      tbl[13] = mk(0, 16'h0000, 0, 1, 8'h04, 0);
      tbl[14] = mk(0, 16'h0000, 0, 0, 8'h00, 0);

      ip_pc[0] = 16'h0008; ip_tk[0] = 1'b1;   // idx 02
      ip_pc[1] = 16'h0404; ip_tk[1] = 1'b0;   // idx 01
      ip_pc[2] = 16'h0ABC; ip_tk[2] = 1'b1;   // idx AF
      ip_pc[3] = 16'h3330; ip_tk[3] = 1'b1;   // idx CC
      ip_pc[4] = 16'h0050; ip_tk[4] = 1'b0;   // idx 14, dropped
      ip_pc[5] = 16'h0060; ip_tk[5] = 1'b1;   // idx 18, dropped

      rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; flush_req = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_cmd", cmd(), 32'd0);
      chk("rst_ready", {31'd0, upd_ready}, 32'd0);
      chk("rst_drop", {16'd0, drop_cnt}, 32'd0);

      // Sweep after reset release
      rst = 1'b0;
      sweep("sweep_reset", 0, 256);
      step();
      chk("post_sweep_pv", cmd(), {20'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
      chk_model_init("model_init_reset");

      // RUN traffic from the vector table
      for (int i = 0; i < 15; i++) begin
         upd_valid = tbl[i].v;
         upd_pc    = tbl[i].pc;
         upd_taken = tbl[i].tk;
         step();
         if (tbl[i].e_we)
            chk($sformatf("tbl%0d_cmd", i), cmd(),
                {20'd0, 1'b1, 1'b0, tbl[i].e_tk, tbl[i].e_addr, 1'b1});
         else
            chk($sformatf("tbl%0d_idle", i), {30'd0, pht_we, pred_valid}, 32'd1);
         chk($sformatf("tbl%0d_ready", i), {31'd0, upd_ready}, 32'd1);
      end
      upd_valid = 1'b0;
      chk("tbl_drop", {16'd0, drop_cnt}, 32'd0);
      chk("model_49", {30'd0, pht_m[8'h49]}, 32'd2);
      chk("model_00", {30'd0, pht_m[8'h00]}, 32'd3);
      chk("model_ff", {30'd0, pht_m[8'hFF]}, 32'd3);
      chk("model_01", {30'd0, pht_m[8'h01]}, 32'd0);

      // Flush, then 6 pushes during the sweep: 4 accepted, 2 dropped
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("flush1_cmd", cmd(), 32'd0);
      sweep("sweep_push6", 6, 256);
      chk("init_drop", {16'd0, drop_cnt}, 32'd2);
      step();
      chk("drain0", cmd(), {20'd0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1});
      step();
      chk("drain1", cmd(), {20'd0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1});
      step();
      chk("drain2", cmd(), {20'd0, 1'b1, 1'b0, 1'b1, 8'hAF, 1'b1});
      step();
      chk("drain3", cmd(), {20'd0, 1'b1, 1'b0, 1'b1, 8'hCC, 1'b1});
      step();
      chk("drain_idle", cmd(), 32'd1);

      // Queue 3 during a sweep, then flush in the first RUN cycle with a push
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      sweep("sweep_q3", 3, 256);
      flush_req = 1'b1; upd_valid = 1'b1; upd_pc = 16'h0060; upd_taken = 1'b1;
      chk("flush2_ready", {31'd0, upd_ready}, 32'd1);
      step();
      flush_req = 1'b0; upd_valid = 1'b0;
      chk("flush2_cmd", cmd(), 32'd0);
      sweep("sweep_after_flush", 0, 256);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("no_stale%0d", i), {30'd0, pht_we, pred_valid}, 32'd1);
      end
      chk("flush_keeps_drop", {16'd0, drop_cnt}, 32'd2);

      // Flush partway through the sweep at idx 100
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      sweep("sweep_part", 0, 100);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("flush_mid_cmd", cmd(), 32'd0);
      sweep("sweep_restart", 0, 256);
      step();
      chk("restart_pv", cmd(), 32'd1);

      // rst and flush together: reset wins, drop count cleared
      rst = 1'b1; flush_req = 1'b1;
      step();
      chk("rstflush_cmd", cmd(), 32'd0);
      chk("rstflush_drop", {16'd0, drop_cnt}, 32'd0);
      chk("rstflush_ready", {31'd0, upd_ready}, 32'd0);
      rst = 1'b0; flush_req = 1'b0;
      sweep("sweep_rst2", 0, 256);
      step();
      chk("final_pv", cmd(), 32'd1);
      chk_model_init("model_init_final");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
